// File: rtl/arb_pkg.sv
// Shared types and default parameters for the round-robin resource arbiter.
package arb_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE    = 2'd0,
      ARB_GRANT   = 2'd1,
      ARB_RECOVER = 2'd2
   } arb_state_t;

   localparam int DEFAULT_N_REQ    = 4;
   localparam int DEFAULT_HOLD_MAX = 8;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request bit strictly after 'last', wrapping.
module rr_pick
   import arb_pkg::*;
#(
   parameter int N_REQ = DEFAULT_N_REQ,
   parameter int IDX_W = $clog2(DEFAULT_N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] last,
   output logic             any,
   output logic [IDX_W-1:0] idx,
   output logic [N_REQ-1:0] onehot
);

   always_comb begin
      any    = 1'b0;
      idx    = '0;
      onehot = '0;
      // Offset N_REQ wraps back to 'last' itself, so a lone releasing requester can win again.
      for (int k = 1; k <= N_REQ; k++) begin
         int j;
         j = (int'(last) + k) % N_REQ;
         if (!any && req[j]) begin
            any = 1'b1;
            idx = j[IDX_W-1:0];
         end
      end
      if (any) begin
         onehot[idx] = 1'b1;
      end
   end

endmodule

// File: rtl/rr_resource_arbiter.sv
// Round-robin arbiter with IDLE/GRANT/RECOVER controller and one dead cycle between grants.
// Optional forced release after HOLD_MAX grant cycles when ARB_TIMEOUT_EN is defined.
module rr_resource_arbiter
   import arb_pkg::*;
#(
   parameter int N_REQ    = DEFAULT_N_REQ,
   parameter int HOLD_MAX = DEFAULT_HOLD_MAX
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [N_REQ-1:0]         req,
   input  logic                     done,
   output logic [N_REQ-1:0]         gnt,
   output logic                     gnt_valid,
   output logic [$clog2(N_REQ)-1:0] gnt_id,
   output logic                     timeout
);

   localparam int IDX_W = $clog2(N_REQ);

   if (N_REQ < 2 || HOLD_MAX < 2) begin : g_bad_params
      $error("rr_resource_arbiter: N_REQ and HOLD_MAX must both be >= 2");
   end

   arb_state_t       state_q, state_d;
   logic [N_REQ-1:0] gnt_q, gnt_d;
   logic [IDX_W-1:0] gnt_id_q, gnt_id_d;
   logic [IDX_W-1:0] last_q, last_d;
   logic             timeout_q, timeout_d;

   logic             pick_any;
   logic [IDX_W-1:0] pick_idx;
   logic [N_REQ-1:0] pick_onehot;
   logic             release_now;

   rr_pick #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_pick (
      .req    (req),
      .last   (last_q),
      .any    (pick_any),
      .idx    (pick_idx),
      .onehot (pick_onehot)
   );

   assign release_now = done || !req[gnt_id_q];

`ifdef ARB_TIMEOUT_EN
   localparam int HOLD_W = $clog2(HOLD_MAX);
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic              hold_limit;

   assign hold_limit = (hold_q == HOLD_W'(HOLD_MAX - 1));
`else
   logic              hold_limit;

   assign hold_limit = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      gnt_id_d  = gnt_id_q;
      last_d    = last_q;
      timeout_d = 1'b0;
`ifdef ARB_TIMEOUT_EN
      hold_d    = hold_q;
`endif
      case (state_q)
         ARB_IDLE, ARB_RECOVER: begin
            if (pick_any) begin
               state_d  = ARB_GRANT;
               gnt_d    = pick_onehot;
               gnt_id_d = pick_idx;
               last_d   = pick_idx;
`ifdef ARB_TIMEOUT_EN
               hold_d   = '0;
`endif
            end else begin
               state_d  = ARB_IDLE;
               gnt_d    = '0;
               gnt_id_d = '0;
            end
         end
         ARB_GRANT: begin
            // A real release takes precedence over the hold limit, so no timeout pulse then.
            if (release_now || hold_limit) begin
               state_d   = ARB_RECOVER;
               gnt_d     = '0;
               gnt_id_d  = '0;
               timeout_d = !release_now;
            end else begin
`ifdef ARB_TIMEOUT_EN
               hold_d = hold_q + 1'b1;
`endif
            end
         end
         default: begin
            state_d  = ARB_IDLE;
            gnt_d    = '0;
            gnt_id_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ARB_IDLE;
         gnt_q     <= '0;
         gnt_id_q  <= '0;
         last_q    <= IDX_W'(N_REQ - 1);
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         gnt_id_q  <= gnt_id_d;
         last_q    <= last_d;
         timeout_q <= timeout_d;
      end
   end

`ifdef ARB_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         hold_q <= '0;
      end else begin
         hold_q <= hold_d;
      end
   end
`endif

   assign gnt       = gnt_q;
   assign gnt_valid = |gnt_q;
   assign gnt_id    = gnt_id_q;
   assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_resource_arbiter.sv
// Directed self-checking bench for rr_resource_arbiter (N_REQ=4, HOLD_MAX=8).
module tb_rr_resource_arbiter;

   logic       clk;
   logic       reset;
   logic [3:0] req;
   logic       done;
   logic [3:0] gnt;
   logic       gnt_valid;
   logic [1:0] gnt_id;
   logic       timeout;

   int n_checks;
   int n_pass;

   rr_resource_arbiter #(
      .N_REQ    (4),
      .HOLD_MAX (8)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .done      (done),
      .gnt       (gnt),
      .gnt_valid (gnt_valid),
      .gnt_id    (gnt_id),
      .timeout   (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle 1ns past it before sampling.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      done  = 1'b0;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      req = 4'b0000;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         step();
         n_checks++;
         if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || gnt_id !== 2'd0 || timeout !== 1'b0)
            $display("[TB] FAIL reset_idle cycle %0d: gnt=%b valid=%b id=%0d to=%b, want 0000/0/0/0",
                     i, gnt, gnt_valid, gnt_id, timeout);
         else
            n_pass++;
      end
   endtask

   task automatic test_basic();
      req = 4'b1010;
      do_reset();
      step();
      n_checks++;
      if (gnt !== 4'b0010 || gnt_id !== 2'd1 || gnt_valid !== 1'b1)
         $display("[TB] FAIL basic_first: gnt=%b id=%0d valid=%b, want 0010/1/1", gnt, gnt_id, gnt_valid);
      else
         n_pass++;
      done = 1'b1;
      step();
      done = 1'b0;
      n_checks++;
      if (gnt !== 4'b0000 || gnt_valid !== 1'b0)
         $display("[TB] FAIL basic_dead: gnt=%b valid=%b, want 0000/0", gnt, gnt_valid);
      else
         n_pass++;
      step();
      n_checks++;
      if (gnt !== 4'b1000 || gnt_id !== 2'd3)
         $display("[TB] FAIL basic_second: gnt=%b id=%0d, want 1000/3", gnt, gnt_id);
      else
         n_pass++;
      req = 4'b0000;
      step();
      step();
   endtask

   task automatic test_round_robin();
      logic [3:0] exp_order [5];
      exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      req = 4'b1111;
      do_reset();
      step();
      for (int i = 0; i < 5; i++) begin
         n_checks++;
         if (gnt !== exp_order[i])
            $display("[TB] FAIL rr_grant %0d: gnt=%b, want %b", i, gnt, exp_order[i]);
         else
            n_pass++;
         step();
         n_checks++;
         if (gnt !== exp_order[i])
            $display("[TB] FAIL rr_hold %0d: gnt=%b, want %b", i, gnt, exp_order[i]);
         else
            n_pass++;
         done = 1'b1;
         step();
         done = 1'b0;
         n_checks++;
         if (gnt !== 4'b0000)
            $display("[TB] FAIL rr_dead %0d: gnt=%b, want 0000", i, gnt);
         else
            n_pass++;
         step();
      end
      req = 4'b0000;
      step();
      step();
   endtask

   task automatic test_drop_req();
      req = 4'b1100;
      do_reset();
      step();
      n_checks++;
      if (gnt !== 4'b0100 || gnt_id !== 2'd2)
         $display("[TB] FAIL drop_first: gnt=%b id=%0d, want 0100/2", gnt, gnt_id);
      else
         n_pass++;
      step();
      req = 4'b1000;
      step();
      n_checks++;
      if (gnt !== 4'b0000 || timeout !== 1'b0)
         $display("[TB] FAIL drop_release: gnt=%b to=%b, want 0000/0", gnt, timeout);
      else
         n_pass++;
      step();
      n_checks++;
      if (gnt !== 4'b1000 || gnt_id !== 2'd3)
         $display("[TB] FAIL drop_next: gnt=%b id=%0d, want 1000/3", gnt, gnt_id);
      else
         n_pass++;
      req = 4'b0000;
      step();
      step();
   endtask

   task automatic test_timeout();
      int high_cycles;
      req = 4'b0001;
      do_reset();
      step();
      high_cycles = 0;
`ifdef ARB_TIMEOUT_EN
      while (gnt !== 4'b0000 && high_cycles < 20) begin
         high_cycles++;
         n_checks++;
         if (timeout !== 1'b0 || gnt !== 4'b0001)
            $display("[TB] FAIL timeout_hold %0d: gnt=%b to=%b, want 0001/0", high_cycles, gnt, timeout);
         else
            n_pass++;
         step();
      end
      n_checks++;
      if (high_cycles != 8 || timeout !== 1'b1 || gnt !== 4'b0000)
         $display("[TB] FAIL timeout_force: high=%0d to=%b gnt=%b, want 8/1/0000", high_cycles, timeout, gnt);
      else
         n_pass++;
      step();
      n_checks++;
      if (gnt !== 4'b0001 || timeout !== 1'b0)
         $display("[TB] FAIL timeout_regrant: gnt=%b to=%b, want 0001/0", gnt, timeout);
      else
         n_pass++;
`else
      for (int i = 0; i < 20; i++) begin
         high_cycles++;
         n_checks++;
         if (gnt !== 4'b0001 || timeout !== 1'b0)
            $display("[TB] FAIL no_timeout_hold %0d: gnt=%b to=%b, want 0001/0", high_cycles, gnt, timeout);
         else
            n_pass++;
         step();
      end
`endif
      req = 4'b0000;
      step();
      step();
   endtask

   task automatic test_reset_mid_grant();
      req = 4'b0011;
      do_reset();
      step();
      done = 1'b1;
      step();
      done = 1'b0;
      step();
      n_checks++;
      if (gnt !== 4'b0010)
         $display("[TB] FAIL midrst_setup: gnt=%b, want 0010", gnt);
      else
         n_pass++;
      reset = 1'b1;
      req   = 4'b1010;
      step();
      n_checks++;
      if (gnt !== 4'b0000 || timeout !== 1'b0 || gnt_valid !== 1'b0)
         $display("[TB] FAIL midrst_drop: gnt=%b to=%b valid=%b, want 0000/0/0", gnt, timeout, gnt_valid);
      else
         n_pass++;
      reset = 1'b0;
      step();
      // Pointer back at N_REQ-1, so requester 1 beats 3 even though 1 owned last.
      n_checks++;
      if (gnt !== 4'b0010 || gnt_id !== 2'd1)
         $display("[TB] FAIL midrst_pointer: gnt=%b id=%0d, want 0010/1", gnt, gnt_id);
      else
         n_pass++;
      req = 4'b1000;
      step();
      step();
      n_checks++;
      if (gnt !== 4'b1000 || gnt_id !== 2'd3)
         $display("[TB] FAIL midrst_req3: gnt=%b id=%0d, want 1000/3", gnt, gnt_id);
      else
         n_pass++;
      req = 4'b0000;
      step();
      step();
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      reset    = 1'b1;
      req      = 4'b0000;
      done     = 1'b0;
      test_reset();
      test_basic();
      test_round_robin();
      test_drop_req();
      test_timeout();
      test_reset_mid_grant();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
